// File: rtl/tb_exit_pkg.sv
// Shared constants and types for the test-status peripheral.
// Register map, state codes and default magic values.
package tb_exit_pkg;

  localparam logic [31:0] TB_EXIT_BASE_ADDR = 32'h2000_0000;
  localparam logic [31:0] TB_EXIT_PASS_MAGIC = 32'd123456789;
  localparam logic [31:0] TB_EXIT_FAIL_MAGIC = 32'd1;
  localparam logic [31:0] TB_EXIT_DEF_MAXCYC = 32'd0;

  localparam logic [4:0] OFF_STATUS = 5'h00;
  localparam logic [4:0] OFF_EXIT = 5'h04;
  localparam logic [4:0] OFF_MAXCYC = 5'h08;
  localparam logic [4:0] OFF_CYC_LO = 5'h0C;
  localparam logic [4:0] OFF_CYC_HI = 5'h10;

  typedef enum logic [2:0] {
    ST_RUN = 3'd0,
    ST_PASSED = 3'd1,
    ST_FAILED = 3'd2,
    ST_EXITED = 3'd3,
    ST_TIMEOUT = 3'd4
  } tb_exit_state_e;

endpackage

// File: rtl/tb_cycle_counter.sv
// 64-bit free-running cycle counter with enable and clear,
// plus the watchdog limit comparator on the low word.
module tb_cycle_counter (
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] limit_i,
  output logic [63:0] count_o,
  output logic        expired_o
);

  logic [63:0] cnt_q;

  // count up while enabled, wrapping silently
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign count_o = cnt_q;
  assign expired_o = (limit_i != '0) && (cnt_q[31:0] >= limit_i);

endmodule

// File: rtl/tb_exit_periph.sv
// Test-status peripheral: bus snoop, status FSM, cycle counter.
// Watchdog built only when TB_EXIT_WATCHDOG_EN is defined.
module tb_exit_periph
  import tb_exit_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TB_EXIT_BASE_ADDR,
  parameter logic [31:0] PASS_MAGIC = TB_EXIT_PASS_MAGIC,
  parameter logic [31:0] FAIL_MAGIC = TB_EXIT_FAIL_MAGIC,
  parameter logic [31:0] DEFAULT_MAXCYCLES = TB_EXIT_DEF_MAXCYC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic        timeout_o
);

  tb_exit_state_e state_q, state_d;
  logic [31:0] exit_q, exit_d;
  logic [31:0] maxcyc;
  logic [31:0] rdata_d;
  logic [63:0] cycle;
  logic        expired;
  logic        wd_fire;
  logic        hit;
  logic        wr_ok;
  logic [2:0]  sel;
  logic        pass_wr;
  logic        fail_wr;
  logic        exit_wr;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        unused_addr;

  assign unused_addr = ^addr_i[1:0];

  assign hit = req_i && (addr_i[31:5] == BASE_ADDR[31:5]);
  assign sel = addr_i[4:2];
  assign wr_ok = hit && we_i && (be_i == 4'hF);
  assign gnt_o = hit;

  assign pass_wr = wr_ok && (sel == OFF_STATUS[4:2])
                && (wdata_i == PASS_MAGIC);
  assign fail_wr = wr_ok && (sel == OFF_STATUS[4:2])
                && (wdata_i == FAIL_MAGIC);
  assign exit_wr = wr_ok && (sel == OFF_EXIT[4:2]);

  tb_cycle_counter u_cnt (
    .clk_i     (clk_i),
    .clr_i     (rst_i),
    .en_i      (state_q == ST_RUN),
    .limit_i   (maxcyc),
    .count_o   (cycle),
    .expired_o (expired)
  );

`ifdef TB_EXIT_WATCHDOG_EN
  logic [31:0] maxcyc_q;

  // MAXCYCLES register, full-word writes only
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      maxcyc_q <= DEFAULT_MAXCYCLES;
    end else if (wr_ok && (sel == OFF_MAXCYC[4:2])) begin
      maxcyc_q <= wdata_i;
    end
  end

  assign maxcyc = maxcyc_q;
  assign wd_fire = expired;
  assign timeout_o = (state_q == ST_TIMEOUT);
`else
  logic unused_wd;

  assign unused_wd = ^{expired, DEFAULT_MAXCYCLES};
  assign maxcyc = '0;
  assign wd_fire = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // next state: first terminal event wins, firmware beats watchdog
  always_comb begin
    state_d = state_q;
    exit_d = exit_q;
    if (state_q == ST_RUN) begin
      unique case (1'b1)
        pass_wr: state_d = ST_PASSED;
        fail_wr: state_d = ST_FAILED;
        exit_wr: begin
          state_d = ST_EXITED;
          exit_d = wdata_i;
        end
        default: begin
          if (wd_fire) begin
            state_d = ST_TIMEOUT;
          end
        end
      endcase
    end
  end

  // state and latched exit code
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      exit_q <= '0;
    end else begin
      state_q <= state_d;
      exit_q <= exit_d;
    end
  end

  // read mux sees values before this cycle's updates
  always_comb begin
    rdata_d = '0;
    case (sel)
      OFF_STATUS[4:2]: rdata_d = {29'd0, state_q};
      OFF_MAXCYC[4:2]: rdata_d = maxcyc;
      OFF_CYC_LO[4:2]: rdata_d = cycle[31:0];
      OFF_CYC_HI[4:2]: rdata_d = cycle[63:32];
      default:         rdata_d = '0;
    endcase
  end

  // one-cycle response; reset drops anything in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      rvalid_q <= hit;
      rdata_q <= (hit && !we_i) ? rdata_d : '0;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o = rdata_q;
  assign tests_passed_o = (state_q == ST_PASSED);
  assign tests_failed_o = (state_q == ST_FAILED)
                       || (state_q == ST_TIMEOUT);
  assign exit_valid_o = (state_q == ST_EXITED);
  assign exit_value_o = exit_q;

endmodule

// File: tb/tb_tb_exit_periph.sv
// Self-checking bench for tb_exit_periph: vector table,
// directed corner sequences and randomized model checks.
module tb_tb_exit_periph;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam logic [31:0] PASS = 32'd123456789;
  localparam logic [31:0] FAIL = 32'd1;
`ifdef TB_EXIT_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        tests_passed_o;
  logic        tests_failed_o;
  logic        exit_valid_o;
  logic [31:0] exit_value_o;
  logic        timeout_o;

  always #5 clk = ~clk;

  tb_exit_periph dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .we_i           (we_i),
    .addr_i         (addr_i),
    .be_i           (be_i),
    .wdata_i        (wdata_i),
    .gnt_o          (gnt_o),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .tests_passed_o (tests_passed_o),
    .tests_failed_o (tests_failed_o),
    .exit_valid_o   (exit_valid_o),
    .exit_value_o   (exit_value_o),
    .timeout_o      (timeout_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  // reference model: state code, cycle count, registers
  int              m_state;
  longint unsigned m_cyc;
  logic [31:0]     m_max;
  logic [31:0]     m_exit;
  bit              e_rvalid;
  logic [31:0]     e_rdata;
  bit              last_gnt;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input bit rst, input bit req,
                                input bit we, input logic [31:0] addr,
                                input logic [3:0] be,
                                input logic [31:0] wd);
    bit hit;
    bit wr;
    bit fire;
    int nxt;
    logic [4:0] off;
    if (rst) begin
      m_state = 0;
      m_cyc = 0;
      m_max = 0;
      m_exit = 0;
      e_rvalid = 0;
      e_rdata = 0;
      return;
    end
    hit = req && (addr[31:5] == BASE[31:5]);
    off = {addr[4:2], 2'b00};
    e_rvalid = hit;
    e_rdata = 0;
    if (hit && !we) begin
      case (off)
        5'h00: e_rdata = 32'(m_state);
        5'h08: e_rdata = WD ? m_max : 32'd0;
        5'h0C: e_rdata = m_cyc[31:0];
        5'h10: e_rdata = m_cyc[63:32];
        default: e_rdata = 0;
      endcase
    end
    wr = hit && we && (be == 4'hF);
    fire = WD && (m_state == 0) && (m_max != 0)
        && (m_cyc[31:0] >= m_max);
    nxt = -1;
    if (wr && off == 5'h00 && wd == PASS) nxt = 1;
    else if (wr && off == 5'h00 && wd == FAIL) nxt = 2;
    else if (wr && off == 5'h04) nxt = 3;
    if (m_state == 0) begin
      m_cyc++;
      if (nxt == 3) m_exit = wd;
      if (nxt >= 0) m_state = nxt;
      else if (fire) m_state = 4;
    end
    if (WD && wr && off == 5'h08) m_max = wd;
  endfunction

  task automatic step(input bit rst, input bit req, input bit we,
                      input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd);
    rst_i = rst;
    req_i = req;
    we_i = we;
    addr_i = addr;
    be_i = be;
    wdata_i = wd;
    #1;
    last_gnt = gnt_o;
    chk("gnt", gnt_o, req && (addr[31:5] == BASE[31:5]));
    @(posedge clk);
    model(rst, req, we, addr, be, wd);
    #1;
    chk("rvalid", rvalid_o, e_rvalid);
    chk("rdata", rdata_o, e_rdata);
    chk("passed", tests_passed_o, m_state == 1);
    chk("failed", tests_failed_o, m_state == 2 || m_state == 4);
    chk("exit_valid", exit_valid_o, m_state == 3);
    chk("exit_value", exit_value_o, m_exit);
    chk("timeout", timeout_o, m_state == 4);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
  endtask

  task automatic reset();
    step(1'b1, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] v);
    step(1'b0, 1'b1, 1'b1, BASE | 32'(off), 4'hF, v);
  endtask

  task automatic rd(input logic [4:0] off);
    step(1'b0, 1'b1, 1'b0, BASE | 32'(off), 4'hF, 32'd0);
  endtask

  typedef struct {
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          e_gnt;
    bit          e_rv;
    logic [31:0] e_rd;
    bit          e_pass;
    bit          e_fail;
    bit          e_exit;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input bit req, input bit we,
                              input logic [31:0] addr,
                              input logic [3:0] be,
                              input logic [31:0] wd, input bit g,
                              input bit rv, input logic [31:0] rdv,
                              input bit p, input bit f, input bit e);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.be = be; v.wd = wd;
    v.e_gnt = g; v.e_rv = rv; v.e_rd = rdv;
    v.e_pass = p; v.e_fail = f; v.e_exit = e;
    return v;
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] v;
    logic [3:0]  b;
    bit          r;
    bit          q;
    bit          w;

    tbl[0] = mk(1'b1, 1'b0, BASE, 4'hF, 32'd0,
                1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    tbl[1] = mk(1'b1, 1'b1, BASE, 4'h3, FAIL,
                1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    tbl[2] = mk(1'b1, 1'b1, BASE, 4'hF, 32'd7,
                1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    tbl[3] = mk(1'b1, 1'b0, BASE, 4'hF, 32'd0,
                1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    tbl[4] = mk(1'b1, 1'b1, 32'h3000_0000, 4'hF, PASS,
                1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tbl[5] = mk(1'b1, 1'b0, BASE + 32'h14, 4'hF, 32'd0,
                1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    tbl[6] = mk(1'b1, 1'b1, BASE + 32'h18, 4'hF, PASS,
                1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    tbl[7] = mk(1'b1, 1'b0, BASE + 32'h20, 4'hF, 32'd0,
                1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tbl[8] = mk(1'b1, 1'b1, BASE, 4'hF, PASS,
                1'b1, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
    tbl[9] = mk(1'b1, 1'b0, BASE, 4'hF, 32'd0,
                1'b1, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 1'b1, BASE, 4'hF, FAIL,
                 1'b1, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 1'b1, BASE + 32'h4, 4'hF, 32'd9,
                 1'b1, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, BASE, 4'hF, 32'd0,
                 1'b1, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);

    reset();
    reset();
    chk("rst_rvalid", rvalid_o, 1'b0);
    chk("rst_status", {tests_passed_o, tests_failed_o,
                       exit_valid_o, timeout_o}, 4'h0);

    for (int i = 0; i < 13; i++) begin
      step(1'b0, tbl[i].req, tbl[i].we, tbl[i].addr,
           tbl[i].be, tbl[i].wd);
      chk($sformatf("tbl%0d_gnt", i), last_gnt, tbl[i].e_gnt);
      chk($sformatf("tbl%0d_rv", i), rvalid_o, tbl[i].e_rv);
      chk($sformatf("tbl%0d_rd", i), rdata_o, tbl[i].e_rd);
      chk($sformatf("tbl%0d_pass", i), tests_passed_o,
          tbl[i].e_pass);
      chk($sformatf("tbl%0d_fail", i), tests_failed_o,
          tbl[i].e_fail);
      chk($sformatf("tbl%0d_exit", i), exit_valid_o,
          tbl[i].e_exit);
    end

    // exit first, then fail: exit wins
    reset();
    wr(5'h04, 32'd5);
    wr(5'h00, FAIL);
    chk("exit_first_valid", exit_valid_o, 1'b1);
    chk("exit_first_value", exit_value_o, 32'd5);
    chk("exit_first_failed", tests_failed_o, 1'b0);

    // reset while passed with a read in flight
    reset();
    wr(5'h00, PASS);
    chk("pre_rst_passed", tests_passed_o, 1'b1);
    step(1'b1, 1'b1, 1'b0, BASE | 32'h0C, 4'hF, 32'd0);
    chk("midrst_rvalid", rvalid_o, 1'b0);
    chk("midrst_rdata", rdata_o, 32'd0);
    chk("midrst_passed", tests_passed_o, 1'b0);
    rd(5'h0C);
    chk("cyc_restart0", rdata_o, 32'd0);
    rd(5'h0C);
    chk("cyc_restart1", rdata_o, 32'd1);

`ifdef TB_EXIT_WATCHDOG_EN
    // MAXCYCLES=100 written at cycle 10
    reset();
    for (int i = 0; i < 10; i++) idle();
    wr(5'h08, 32'd100);
    for (int k = 0; k < 300 && !timeout_o; k++) idle();
    chk("wd_timeout", timeout_o, 1'b1);
    chk("wd_failed", tests_failed_o, 1'b1);
    rd(5'h0C);
    chk("wd_frozen_lo", rdata_o, 32'd101);
    idle();
    rd(5'h0C);
    chk("wd_frozen_lo2", rdata_o, 32'd101);
    rd(5'h08);
    chk("wd_max_rd", rdata_o, 32'd100);

    // firmware exit in the expiry cycle beats the watchdog
    reset();
    wr(5'h08, 32'd5);
    for (int k = 0; k < 20 && m_cyc < 5; k++) idle();
    wr(5'h04, 32'd0);
    chk("race_exit", exit_valid_o, 1'b1);
    chk("race_timeout", timeout_o, 1'b0);
    chk("race_value", exit_value_o, 32'd0);

    // limit written below current count
    reset();
    for (int i = 0; i < 20; i++) idle();
    wr(5'h08, 32'd3);
    chk("late_max_t0", timeout_o, 1'b0);
    idle();
    chk("late_max_t1", timeout_o, 1'b1);
`else
    reset();
    wr(5'h08, 32'd100);
    rd(5'h08);
    chk("nowd_max_rd", rdata_o, 32'd0);
    for (int i = 0; i < 5; i++) idle();
    chk("nowd_timeout", timeout_o, 1'b0);
`endif

    // randomized traffic against the model
    reset();
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) < 5);
      q = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = BASE | (32'($urandom_range(0, 7)) << 2)
             | 32'($urandom_range(0, 3));
      b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      case ($urandom_range(0, 9))
        0: v = PASS;
        1: v = FAIL;
        2, 3: v = $urandom;
        default: v = 32'($urandom_range(0, 60));
      endcase
      step(r, q, w, a, b, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
